// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch sequencer: issues one word read per cycle, buffers {word, pc} in a prefetch FIFO.
// Optional misaligned-redirect fault state is enabled by defining FETCH_ALIGN_CHECK_EN.
module imem_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  output logic        fetch_fault
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(DEPTH);

`ifdef FETCH_ALIGN_CHECK_EN
  typedef enum logic {RUN = 1'b0, FAULT = 1'b1} state_e;
`else
  typedef enum logic {RUN = 1'b0} state_e;
`endif

  state_e           state_q, state_d;
  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic             inflight_q, inflight_d;
  logic [31:0]      inflight_pc_q, inflight_pc_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [31:0]      data_mem [DEPTH];
  logic [31:0]      pc_mem   [DEPTH];

  logic             pop, push, credit;
  logic [CNT_W:0]   occupancy;
  logic [31:0]      redir_target;

  assign inst_valid = (count_q != '0);
  assign inst       = inst_valid ? data_mem[rd_ptr_q] : 32'h0;
  assign inst_pc    = inst_valid ? pc_mem[rd_ptr_q]   : 32'h0;
  assign pop        = inst_valid & inst_ready;
  // A response arriving in a redirect cycle belongs to the old stream and is dropped.
  assign push       = inflight_q & ~redirect_valid;
  assign occupancy  = {1'b0, count_q} + (CNT_W + 1)'(inflight_q) - (CNT_W + 1)'(pop);
  assign credit     = (occupancy < DEPTH_C);

`ifdef FETCH_ALIGN_CHECK_EN
  assign redir_target = redirect_pc;
  assign fetch_fault  = (state_q == FAULT);
`else
  assign redir_target = redirect_pc & ~32'h3;
  assign fetch_fault  = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;
    mem_req       = 1'b0;
    mem_addr      = 32'h0;

    if (!rst && (state_q == RUN) && !redirect_valid && credit) begin
      mem_req  = 1'b1;
      mem_addr = fetch_pc_q;
    end

    if (redirect_valid) begin
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      fetch_pc_d = redir_target;
`ifdef FETCH_ALIGN_CHECK_EN
      state_d    = (redirect_pc[1:0] != 2'b00) ? FAULT : RUN;
`else
      state_d    = RUN;
`endif
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      unique case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
      if (mem_req) begin
        inflight_d    = 1'b1;
        inflight_pc_d = fetch_pc_q;
        fetch_pc_d    = fetch_pc_q + 32'd4;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      fetch_pc_q <= RESET_PC;
      inflight_q <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      inflight_q <= inflight_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  // Payload storage carries no reset; visibility is governed by count_q.
  always_ff @(posedge clk) begin
    inflight_pc_q <= inflight_pc_d;
    if (push) begin
      data_mem[wr_ptr_q] <= mem_rdata;
      pc_mem[wr_ptr_q]   <= inflight_pc_q;
    end
  end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Self-checking bench for imem_fetch_ctrl: directed scenarios plus randomized ready/redirect traffic
// checked against a transaction-level model of issued/buffered fetches.
module tb_imem_fetch_ctrl;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst, mem_req, redirect_valid, inst_valid, inst_ready, fetch_fault;
  logic [31:0] mem_addr, mem_rdata, redirect_pc, inst, inst_pc;

  always #5 clk = ~clk;

  imem_fetch_ctrl #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .inst_valid(inst_valid),
    .inst(inst), .inst_pc(inst_pc), .inst_ready(inst_ready), .fetch_fault(fetch_fault)
  );

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'h5A5A_A5A5;
  endfunction

  // Synchronous-read memory: word for the address requested in the previous cycle.
  always @(posedge clk) mem_rdata <= mem_req ? word_at(mem_addr) : 32'hDEAD_BEEF;

  int          checks = 0;
  int          errors = 0;
  int          cyc;
  logic [31:0] q_pc[$];
  int          q_cyc[$];
  logic [31:0] fpc_m;
  logic        fault_m;
  logic [31:0] log_pc[$];
  int          log_cyc[$];
  logic        o_req, o_valid, o_fault;
  logic [31:0] o_addr, o_pc;
  int          nreq;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One cycle: sample mid-cycle, compare with the model, then advance the model across the edge.
  task automatic tick();
    int held, infl;
    logic ev, pop, er;
    logic [31:0] epc;
    @(negedge clk);
    o_req = mem_req; o_addr = mem_addr; o_valid = inst_valid; o_pc = inst_pc; o_fault = fetch_fault;
    infl = (q_pc.size() > 0 && q_cyc[$] == cyc - 1) ? 1 : 0;
    held = q_pc.size() - infl;
    ev   = (held > 0);
    epc  = ev ? q_pc[0] : 32'h0;
    pop  = ev && inst_ready;
    er   = !fault_m && !redirect_valid && (held + infl - int'(pop) < DEPTH);
    chk("mem_req", mem_req, er);
    chk("mem_addr", mem_addr, er ? fpc_m : 32'h0);
    chk("inst_valid", inst_valid, ev);
    chk("inst_pc", inst_pc, epc);
    chk("inst", inst, ev ? word_at(epc) : 32'h0);
    chk("fetch_fault", fetch_fault, fault_m);
    if (pop) begin
      log_pc.push_back(q_pc.pop_front());
      void'(q_cyc.pop_front());
      log_cyc.push_back(cyc);
    end
    if (redirect_valid) begin
      q_pc.delete();
      q_cyc.delete();
`ifdef FETCH_ALIGN_CHECK_EN
      fault_m = (redirect_pc[1:0] != 2'b00);
      fpc_m   = redirect_pc;
`else
      fpc_m   = redirect_pc & ~32'h3;
`endif
    end else if (er) begin
      q_pc.push_back(fpc_m);
      q_cyc.push_back(cyc);
      fpc_m = fpc_m + 32'd4;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic redirect_tick(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    tick();
    redirect_valid = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog time limit expired");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; inst_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_inst_valid", inst_valid, 1'b0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_inst_pc", inst_pc, 32'h0);
    chk("rst_fetch_fault", fetch_fault, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0; fpc_m = 32'h0; fault_m = 1'b0;

    // Startup and streaming
    tick();
    chk("c0_req", o_req, 1'b1);
    chk("c0_addr", o_addr, 32'h0);
    tick();
    chk("c1_valid", o_valid, 1'b0);
    tick();
    chk("c2_valid", o_valid, 1'b1);
    chk("c2_pc", o_pc, 32'h0);
    repeat (4) tick();
    chk("c6_pc", o_pc, 32'h10);

    // Stall: exactly DEPTH requests, then release without loss or duplication
    inst_ready = 1'b0;
    redirect_tick(32'h0);
    nreq = 0;
    repeat (10) begin
      tick();
      nreq += int'(o_req);
    end
    chk("stall_nreq", nreq, DEPTH);
    chk("stall_req_low", o_req, 1'b0);
    log_pc.delete(); log_cyc.delete();
    inst_ready = 1'b1;
    repeat (8) tick();
    chk("rel_count", log_pc.size() >= 5, 1'b1);
    for (int i = 0; i < 5; i++) chk("rel_pc", log_pc[i], 32'(4 * i));
    chk("rel_gap", (log_cyc[4] - log_cyc[3]) <= 2, 1'b1);

    // Redirect with 3 buffered entries and one in flight
    inst_ready = 1'b0;
    redirect_tick(32'h0);
    repeat (4) tick();
    chk("pre_redir_valid", o_valid, 1'b1);
    redirect_tick(32'h100);
    inst_ready = 1'b1;
    tick(); chk("stale1", o_valid, 1'b0);
    tick(); chk("stale2", o_valid, 1'b0);
    tick(); chk("r100_valid", o_valid, 1'b1); chk("r100_pc", o_pc, 32'h100);
    tick(); chk("r104_pc", o_pc, 32'h104);

    // Redirect coinciding with a pop
    redirect_tick(32'h300);
    chk("pop_redir_valid", o_valid, 1'b1);
    chk("pop_redir_pc", o_pc, 32'h108);
    tick(); chk("pr_stale1", o_valid, 1'b0);
    tick(); chk("pr_stale2", o_valid, 1'b0);
    tick(); chk("r300_pc", o_pc, 32'h300);

    // Address wrap
    redirect_tick(32'hFFFF_FFF8);
    repeat (3) tick();
    chk("wrap0", o_pc, 32'hFFFF_FFF8);
    tick(); chk("wrap1", o_pc, 32'hFFFF_FFFC);
    tick(); chk("wrap2", o_pc, 32'h0000_0000);

    // Misaligned redirect
    redirect_tick(32'h102);
`ifdef FETCH_ALIGN_CHECK_EN
    tick();
    chk("fault_set", o_fault, 1'b1);
    chk("fault_req", o_req, 1'b0);
    tick();
    tick();
    chk("fault_empty", o_valid, 1'b0);
    redirect_tick(32'h200);
    tick(); chk("fault_clear", o_fault, 1'b0);
    tick();
    tick(); chk("r200_pc", o_pc, 32'h200);
`else
    tick();
    chk("mis_addr", o_addr, 32'h100);
    chk("mis_fault", o_fault, 1'b0);
    tick();
    tick(); chk("mis_pc", o_pc, 32'h100);
`endif

    // Randomized ready/redirect traffic against the model
    repeat (400) begin
      inst_ready     = ($urandom_range(3) != 0);
      redirect_valid = ($urandom_range(15) == 0);
      redirect_pc    = $urandom;
      if ($urandom_range(3) != 0) redirect_pc[1:0] = 2'b00;
      if ($urandom_range(7) == 0) redirect_pc[31:4] = 28'hFFFF_FFF;
      tick();
    end
    redirect_valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
